ethmac_wb_mem_slave: RTL and testbench
======================================

ETHMAC_WB_MEM_SLAVE -- requirements
Module: ethmac_wb_mem_slave

Interface
REQ-001 Parameter DW, default 32: Wishbone data width; SHALL be 8, 16, 32 or 64.
REQ-002 Parameter DEPTH, default 1024: memory depth in DW-bit words; power of two.
REQ-003 Parameter WAIT_STATES, default 0: idle cycles inserted before the first beat of each cycle; range 0..15.
REQ-004 Parameter BASE_ADDR, default 32'h0: byte address of word 0.
REQ-005 wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-006 wb_rst_n_i  in  1  reset, asynchronous and active-low.
REQ-007 wb_adr_i  in  32  byte address from the ethmac master port.
REQ-008 wb_dat_i  in  DW  write data.
REQ-009 wb_dat_o  out  DW  read data.
REQ-010 wb_sel_i  in  DW/8  byte-lane enables.
REQ-011 wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  write enable, cycle, strobe.
REQ-012 wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
REQ-013 wb_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-014 wb_ack_o, wb_err_o  out  1 each  beat acknowledge, beat error.
REQ-015 beat_cnt_o  out  16  count of beats terminated by ack, wraps 16'hFFFF->0.

Function
REQ-016 Word index SHALL be (wb_adr_i - BASE_ADDR) >> log2(DW/8); in range iff wb_adr_i >= BASE_ADDR and index < DEPTH.
REQ-017 FSM states SHALL be IDLE, WAIT, BEAT, BURST.
REQ-018 IDLE: on wb_cyc_i&wb_stb_i, latch index, we, cti, bte; go WAIT if WAIT_STATES>0 else BEAT.
REQ-019 WAIT: count WAIT_STATES cycles then go BEAT; ack/err low throughout.
REQ-020 First-beat latency SHALL be WAIT_STATES+1 cycles from the cycle stb is sampled to ack/err high.
REQ-021 BEAT: drive ack (in range) or err (out of range) for exactly one cycle; read data valid on wb_dat_o in that cycle.
REQ-022 After BEAT: if latched cti==010 and stb still high, go BURST; otherwise go IDLE.
REQ-023 BURST: one beat per cycle while cyc&stb high, no wait states; next index per bte.
REQ-024 bte 00: index+1; bte 01/10/11: increment low 2/3/4 index bits only, upper bits held.
REQ-025 BURST SHALL exit to IDLE after the beat acked with wb_cti_i==111, or when stb or cyc drops (no ack that cycle).
REQ-026 Write beats SHALL update only byte lanes with wb_sel_i set, in the ack cycle; reads SHALL not modify memory.
REQ-027 Error beats SHALL not write, SHALL drive wb_dat_o=0, and SHALL terminate any burst (next state IDLE).
REQ-028 ack and err SHALL never be high together, and never high while wb_cyc_i is low.
REQ-029 wb_cyc_i low in WAIT, BEAT or BURST SHALL abort to IDLE next cycle with no write and no ack.
REQ-030 Unsupported cti (001,011-110) SHALL be treated as classic.
REQ-031 beat_cnt_o SHALL increment on each ack cycle; err beats SHALL not count.

Reset
REQ-032 While wb_rst_n_i low: state IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, beat_cnt_o=0, wait counter 0.
REQ-033 Memory contents SHALL not be reset; reset mid-burst SHALL abort with no further writes.
REQ-034 First transfer SHALL be accepted on the first rising edge after wb_rst_n_i deasserts.

Verification
REQ-035 WAIT_STATES=2, classic write 0xDEADBEEF sel=4'hF at 0x10, then read 0x10 -> ack 3 cycles after each stb, read returns 0xDEADBEEF.
REQ-036 Write sel=4'b0010 data 0x0000AB00 over 0xDEADBEEF at 0x10 -> read returns 0xDEADABEF.
REQ-037 Wrap-4 read burst from word 6, 4 beats, last cti=111 -> indices 6,7,4,5; 4 consecutive acks; beat_cnt_o +4.
REQ-038 Read at BASE_ADDR+DEPTH*4 -> err high one cycle, ack low, wb_dat_o=0, beat_cnt_o unchanged.
REQ-039 Linear burst starting at word DEPTH-2, 4 beats -> ack, ack, err, then IDLE; no write beyond DEPTH-1.
REQ-040 Drop cyc during WAIT, and assert wb_rst_n_i low mid-burst -> no ack, no write, outputs at reset values.

Source files
------------

// File: rtl/ethmac_wb_mem_slave.sv
// ethmac_wb_mem_slave: Wishbone memory slave for the ethmac master port.
// Handles classic cycles and incrementing bursts (linear, wrap-4/8/16),
// with optional wait states before the first beat. Out-of-range beats are
// answered with err. Memory contents survive reset.
module ethmac_wb_mem_slave #(
  parameter int          DW          = 32,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [31:0]     wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [15:0]     beat_cnt_o
);

  localparam int          NB      = DW / 8;
  localparam int          BW      = $clog2(NB);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_BURST} state_t;

  // Burst address step: wrap modes advance only the low 2/3/4 index bits.
  function automatic logic [31:0] f_next_idx(input logic [31:0] idx, input logic [1:0] bte);
    logic [31:0] mask;
    case (bte)
      2'b01:   mask = 32'h3;
      2'b10:   mask = 32'h7;
      2'b11:   mask = 32'hF;
      default: mask = '1;
    endcase
    return (idx & ~mask) | ((idx + 32'd1) & mask);
  endfunction

  state_t        r_state;
  logic [31:0]   r_idx;
  logic          r_below;
  logic          r_we;
  logic          r_burst;
  logic [1:0]    r_bte;
  logic [3:0]    r_wait;
  logic [15:0]   r_beat_cnt;
  logic [DW-1:0] r_rd;
  logic [DW-1:0] r_mem [DEPTH];

  logic [31:0]   w_off;
  logic [31:0]   w_idx_nxt;
  logic          w_below_nxt;
  logic          w_req;
  logic          w_beat;
  logic          w_in_range;
  logic          w_ack;
  logic          w_err;
  logic          w_last;

  assign w_off      = wb_adr_i - BASE_ADDR;
  assign w_req      = wb_cyc_i & wb_stb_i;
  // A beat terminates combinationally so a dropped stb/cyc is never acked.
  assign w_beat     = ((r_state == S_BEAT) || (r_state == S_BURST)) && w_req;
  assign w_in_range = !r_below && (r_idx < DEPTH_W);
  assign w_ack      = w_beat && w_in_range;
  assign w_err      = w_beat && !w_in_range;
  assign w_last     = (wb_cti_i == 3'b111);

  assign wb_ack_o   = w_ack;
  assign wb_err_o   = w_err;
  assign wb_dat_o   = w_ack ? r_rd : '0;
  assign beat_cnt_o = r_beat_cnt;

  // Next word index: captured from the address in IDLE, stepped per beat.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_below_nxt = r_below;
    if (r_state == S_IDLE) begin
      if (w_req) begin
        w_idx_nxt   = w_off >> BW;
        w_below_nxt = (wb_adr_i < BASE_ADDR);
      end
    end else if (w_beat) begin
      w_idx_nxt = f_next_idx(r_idx, r_bte);
    end
  end

  // Transfer FSM with latched cycle attributes and the ack beat counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_below    <= 1'b0;
      r_we       <= 1'b0;
      r_burst    <= 1'b0;
      r_bte      <= 2'b00;
      r_wait     <= 4'd0;
      r_beat_cnt <= 16'd0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_below <= w_below_nxt;
      if (w_ack) r_beat_cnt <= r_beat_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= wb_we_i;
            r_burst <= (wb_cti_i == 3'b010);
            r_bte   <= wb_bte_i;
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_wait  <= 4'(WAIT_STATES - 1);
            end else begin
              r_state <= S_BEAT;
            end
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
          end else if (r_wait == 4'd0) begin
            r_state <= S_BEAT;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_BEAT: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
          end else if (wb_stb_i) begin
            if (w_err || !r_burst || w_last) r_state <= S_IDLE;
            else                             r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!w_req || w_err || w_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory array: byte-lane writes on acked write beats, registered read
  // of the word the next beat will address.
  always_ff @(posedge wb_clk_i) begin
    if (w_ack && r_we) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) r_mem[r_idx[AW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
    r_rd <= r_mem[w_idx_nxt[AW-1:0]];
  end

endmodule

// File: tb/tb_ethmac_wb_mem_slave.sv
// Bench for ethmac_wb_mem_slave: directed scenarios plus randomized classic
// and burst traffic checked against an array/index reference model.
module tb_ethmac_wb_mem_slave;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam int          WS    = 2;
  localparam int          LAT   = WS + 1;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel_i = '0;
  logic        we_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0;
  logic [2:0]  cti_i = '0;
  logic [1:0]  bte_i = '0;
  logic        ack_o, err_o;
  logic [15:0] cnt_o;

  always #5 clk = ~clk;

  ethmac_wb_mem_slave #(.DW(DW), .DEPTH(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr_i), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_sel_i(sel_i), .wb_we_i(we_i), .wb_cyc_i(cyc_i),
    .wb_stb_i(stb_i), .wb_cti_i(cti_i), .wb_bte_i(bte_i), .wb_ack_o(ack_o),
    .wb_err_o(err_o), .beat_cnt_o(cnt_o)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_mem [DEPTH];
  logic [15:0] exp_cnt = '0;

  logic [31:0] b_wdat [16];
  logic [3:0]  b_sel  [16];
  logic        b_ack  [16];
  logic        b_err  [16];
  logic [31:0] b_rdat [16];
  int          b_lat;

  // Reference: word index of beat k of a burst starting at word 'start'.
  function automatic int burst_idx(input int start, input logic [1:0] bte, input int k);
    int n;
    if (bte == 2'b00) return start + k;
    n = 2 << bte;
    return (start - (start % n)) + ((start % n) + k) % n;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    merge = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) merge[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  // Master: one classic cycle (burst=0) or an n-beat incrementing burst.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [1:0] bte,
                         input int n, input logic burst);
    int k;
    int start;
    start = int'((adr - BASE) >> 2);
    for (int i = 0; i < 16; i++) begin b_ack[i] = 0; b_err[i] = 0; b_rdat[i] = '0; end
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; bte_i = bte;
    dat_i = b_wdat[0]; sel_i = b_sel[0];
    cti_i = !burst ? 3'b000 : ((n == 1) ? 3'b111 : 3'b010);
    b_lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); b_lat++;
      @(negedge clk);
      if (ack_o || err_o) break;
    end
    k = 0;
    while (1) begin
      b_ack[k] = ack_o; b_err[k] = err_o; b_rdat[k] = dat_o;
      @(posedge clk); #1;
      if (!b_ack[k] || k == n - 1) break;
      k++;
      adr_i = BASE + 32'(burst_idx(start, bte, k) * 4);
      dat_i = b_wdat[k]; sel_i = b_sel[k];
      cti_i = (k == n - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
    end
    cyc_i = 0; stb_i = 0; we_i = 0; cti_i = '0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc_i = 1; stb_i = 1; adr_i = '0;
    @(negedge clk);
    n_chk++; if (ack_o !== 1'b0) $display("FAIL rst_ack: got %b expected 0", ack_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_o); else n_pass++;
    n_chk++; if (dat_o !== 32'h0) $display("FAIL rst_dat: got %h expected 0", dat_o); else n_pass++;
    n_chk++; if (cnt_o !== 16'h0) $display("FAIL rst_cnt: got %h expected 0", cnt_o); else n_pass++;
    cyc_i = 0; stb_i = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < DEPTH; i++) begin
      b_wdat[0] = $urandom; b_sel[0] = 4'hF;
      wb_xfer(BASE + 32'(i * 4), 1'b1, 2'b00, 1, 1'b0);
      n_chk++; if (b_ack[0] !== 1'b1) $display("FAIL init_ack[%0d]: got %b expected 1", i, b_ack[0]); else n_pass++;
      n_chk++; if (b_lat != LAT) $display("FAIL init_lat[%0d]: got %0d expected %0d", i, b_lat, LAT); else n_pass++;
      m_mem[i] = b_wdat[0]; exp_cnt++;
    end
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL init_cnt: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_classic_rw();
    b_wdat[0] = 32'hDEADBEEF; b_sel[0] = 4'hF;
    wb_xfer(32'h10, 1'b1, 2'b00, 1, 1'b0);
    n_chk++; if (b_ack[0] !== 1'b1) $display("FAIL cls_wr_ack: got %b expected 1", b_ack[0]); else n_pass++;
    n_chk++; if (b_lat != LAT) $display("FAIL cls_wr_lat: got %0d expected %0d", b_lat, LAT); else n_pass++;
    m_mem[4] = 32'hDEADBEEF; exp_cnt++;
    wb_xfer(32'h10, 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_lat != LAT) $display("FAIL cls_rd_lat: got %0d expected %0d", b_lat, LAT); else n_pass++;
    n_chk++; if (b_rdat[0] !== 32'hDEADBEEF) $display("FAIL cls_rd_dat: got %h expected deadbeef", b_rdat[0]); else n_pass++;
    exp_cnt++;
    b_wdat[0] = 32'h0000AB00; b_sel[0] = 4'b0010;
    wb_xfer(32'h10, 1'b1, 2'b00, 1, 1'b0);
    m_mem[4] = merge(m_mem[4], 32'h0000AB00, 4'b0010); exp_cnt++;
    wb_xfer(32'h10, 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_rdat[0] !== 32'hDEADABEF) $display("FAIL sel_rd_dat: got %h expected deadabef", b_rdat[0]); else n_pass++;
    exp_cnt++;
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL cls_cnt: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_wrap4();
    int idx;
    wb_xfer(BASE + 32'(6 * 4), 1'b0, 2'b01, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idx = burst_idx(6, 2'b01, k);
      n_chk++; if (b_ack[k] !== 1'b1) $display("FAIL wrap4_ack[%0d]: got %b expected 1", k, b_ack[k]); else n_pass++;
      n_chk++; if (b_rdat[k] !== m_mem[idx]) $display("FAIL wrap4_dat[%0d]: got %h expected %h (word %0d)", k, b_rdat[k], m_mem[idx], idx); else n_pass++;
      exp_cnt++;
    end
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL wrap4_cnt: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_out_of_range();
    wb_xfer(BASE + 32'(DEPTH * 4), 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_err[0] !== 1'b1) $display("FAIL oor_err: got %b expected 1", b_err[0]); else n_pass++;
    n_chk++; if (b_ack[0] !== 1'b0) $display("FAIL oor_ack: got %b expected 0", b_ack[0]); else n_pass++;
    n_chk++; if (b_rdat[0] !== 32'h0) $display("FAIL oor_dat: got %h expected 0", b_rdat[0]); else n_pass++;
    n_chk++; if (b_lat != LAT) $display("FAIL oor_lat: got %0d expected %0d", b_lat, LAT); else n_pass++;
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL oor_cnt: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_linear_end();
    for (int k = 0; k < 4; k++) begin b_wdat[k] = $urandom; b_sel[k] = 4'hF; end
    wb_xfer(BASE + 32'((DEPTH - 2) * 4), 1'b1, 2'b00, 4, 1'b1);
    n_chk++; if (b_ack[0] !== 1'b1) $display("FAIL lin_ack0: got %b expected 1", b_ack[0]); else n_pass++;
    n_chk++; if (b_ack[1] !== 1'b1) $display("FAIL lin_ack1: got %b expected 1", b_ack[1]); else n_pass++;
    n_chk++; if (b_err[2] !== 1'b1 || b_ack[2] !== 1'b0) $display("FAIL lin_err2: got err=%b ack=%b expected err=1 ack=0", b_err[2], b_ack[2]); else n_pass++;
    n_chk++; if (b_ack[3] !== 1'b0 || b_err[3] !== 1'b0) $display("FAIL lin_beat3: got ack=%b err=%b expected 0 0", b_ack[3], b_err[3]); else n_pass++;
    m_mem[DEPTH-2] = b_wdat[0]; m_mem[DEPTH-1] = b_wdat[1]; exp_cnt += 2;
    wb_xfer(BASE, 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_lat != LAT) $display("FAIL lin_idle_lat: got %0d expected %0d", b_lat, LAT); else n_pass++;
    n_chk++; if (b_rdat[0] !== m_mem[0]) $display("FAIL lin_word0: got %h expected %h", b_rdat[0], m_mem[0]); else n_pass++;
    exp_cnt++;
    wb_xfer(BASE + 32'((DEPTH - 1) * 4), 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_rdat[0] !== m_mem[DEPTH-1]) $display("FAIL lin_wordlast: got %h expected %h", b_rdat[0], m_mem[DEPTH-1]); else n_pass++;
    exp_cnt++;
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL lin_cnt: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    logic        seen;
    logic        got;
    logic [31:0] d0;
    logic [31:0] d1;
    // cyc dropped while the slave is still in its wait states
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = BASE + 32'(9 * 4); dat_i = ~m_mem[9]; sel_i = 4'hF; cti_i = 3'b000;
    @(posedge clk);
    @(negedge clk);
    cyc_i = 0; stb_i = 0; we_i = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (ack_o || err_o) seen = 1; end
    n_chk++; if (seen !== 1'b0) $display("FAIL abort_ack: got %b expected 0", seen); else n_pass++;
    wb_xfer(BASE + 32'(9 * 4), 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_rdat[0] !== m_mem[9]) $display("FAIL abort_nowrite: got %h expected %h", b_rdat[0], m_mem[9]); else n_pass++;
    exp_cnt++;
    // reset asserted during the second beat of a write burst
    d0 = $urandom; d1 = ~m_mem[21];
    @(negedge clk);
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = BASE + 32'(20 * 4); dat_i = d0; sel_i = 4'hF; cti_i = 3'b010; bte_i = 2'b00;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_o) begin got = 1; break; end
    end
    n_chk++; if (got !== 1'b1) $display("FAIL rstb_beat0: got %b expected 1", got); else n_pass++;
    @(posedge clk); #1;
    adr_i = BASE + 32'(21 * 4); dat_i = d1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if (ack_o !== 1'b0) $display("FAIL rstb_ack: got %b expected 0", ack_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL rstb_err: got %b expected 0", err_o); else n_pass++;
    n_chk++; if (dat_o !== 32'h0) $display("FAIL rstb_dat: got %h expected 0", dat_o); else n_pass++;
    n_chk++; if (cnt_o !== 16'h0) $display("FAIL rstb_cnt: got %0d expected 0", cnt_o); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc_i = 0; stb_i = 0; we_i = 0; cti_i = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_mem[20] = d0; exp_cnt = '0;
    wb_xfer(BASE + 32'(20 * 4), 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_lat != LAT) $display("FAIL rstb_first_lat: got %0d expected %0d", b_lat, LAT); else n_pass++;
    n_chk++; if (b_rdat[0] !== m_mem[20]) $display("FAIL rstb_word20: got %h expected %h", b_rdat[0], m_mem[20]); else n_pass++;
    exp_cnt++;
    wb_xfer(BASE + 32'(21 * 4), 1'b0, 2'b00, 1, 1'b0);
    n_chk++; if (b_rdat[0] !== m_mem[21]) $display("FAIL rstb_word21: got %h expected %h", b_rdat[0], m_mem[21]); else n_pass++;
    exp_cnt++;
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL rstb_cnt_after: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic        burst;
    logic        we;
    logic [1:0]  bte;
    int          n;
    int          start;
    int          idx;
    logic        stop;
    for (int it = 0; it < 30; it++) begin
      burst = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      bte   = burst ? 2'($urandom_range(0, 3)) : 2'b00;
      n     = burst ? $urandom_range(1, 8) : 1;
      start = $urandom_range(0, DEPTH - 1);
      if (!burst && $urandom_range(0, 5) == 0) start = DEPTH + $urandom_range(0, 7);
      for (int k = 0; k < 16; k++) begin b_wdat[k] = $urandom; b_sel[k] = 4'($urandom_range(0, 15)); end
      wb_xfer(BASE + 32'(start * 4 + $urandom_range(0, 3)), we, bte, n, burst);
      n_chk++; if (b_lat != LAT) $display("FAIL rnd_lat[%0d]: got %0d expected %0d", it, b_lat, LAT); else n_pass++;
      stop = 0;
      for (int k = 0; k < n && !stop; k++) begin
        idx = burst_idx(start, bte, k);
        if (idx >= DEPTH) begin
          n_chk++; if (b_err[k] !== 1'b1 || b_ack[k] !== 1'b0) $display("FAIL rnd_err[%0d.%0d]: got err=%b ack=%b expected err=1 ack=0", it, k, b_err[k], b_ack[k]); else n_pass++;
          stop = 1;
        end else begin
          n_chk++; if (b_ack[k] !== 1'b1 || b_err[k] !== 1'b0) $display("FAIL rnd_ack[%0d.%0d]: got ack=%b err=%b expected ack=1 err=0", it, k, b_ack[k], b_err[k]); else n_pass++;
          if (!we) begin
            n_chk++; if (b_rdat[k] !== m_mem[idx]) $display("FAIL rnd_dat[%0d.%0d]: got %h expected %h (word %0d)", it, k, b_rdat[k], m_mem[idx], idx); else n_pass++;
          end else begin
            m_mem[idx] = merge(m_mem[idx], b_wdat[k], b_sel[k]);
          end
          exp_cnt++;
        end
      end
      n_chk++; if (cnt_o !== exp_cnt) $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", it, cnt_o, exp_cnt); else n_pass++;
    end
    // read everything back to catch stray or missing writes
    for (int i = 0; i < DEPTH; i += 4) begin
      wb_xfer(BASE + 32'(i * 4), 1'b0, 2'b00, 4, 1'b1);
      for (int k = 0; k < 4; k++) begin
        n_chk++; if (b_rdat[k] !== m_mem[i + k]) $display("FAIL sweep_dat[%0d]: got %h expected %h", i + k, b_rdat[k], m_mem[i + k]); else n_pass++;
        exp_cnt++;
      end
    end
    n_chk++; if (cnt_o !== exp_cnt) $display("FAIL sweep_cnt: got %0d expected %0d", cnt_o, exp_cnt); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_classic_rw();
    test_wrap4();
    test_out_of_range();
    test_linear_end();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
